// File: rtl/matmul_pkg.sv
// Shared types and helpers for the output-stationary matrix multiplier.
// State encoding, accumulator width rule and lane slicing for packed vectors.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN
  } state_t;

  // Worst case sum of k_max full-scale products fits without wrap.
  function automatic int acc_width(input int dw, input int k_max);
    return 2 * dw + $clog2(k_max + 1);
  endfunction

endpackage

`ifndef MM_LANE
`define MM_LANE(v, i, w) v[(i)*(w) +: (w)]
`endif

// File: rtl/matmul_array_mac.sv
// One multiply-accumulate cell: acc <= acc + a*b on en, cleared on clr.
// Ports: clk, rst_n, clr, en, a[DW], b[DW] -> acc[AW].
module mac_cell #(
  parameter int DW     = 4,
  parameter int AW     = 13,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc
);

  logic            a_s;
  logic            b_s;
  logic            p_s;
  logic [2*DW-1:0] a_x;
  logic [2*DW-1:0] b_x;
  logic [2*DW-1:0] prod;
  logic [AW-1:0]   prod_x;

  // Extending operands to 2*DW first makes the low 2*DW bits of the
  // product correct for both signed and unsigned operands.
  always_comb begin
    a_s    = (SIGNED != 0) ? a[DW-1] : 1'b0;
    b_s    = (SIGNED != 0) ? b[DW-1] : 1'b0;
    a_x    = {{DW{a_s}}, a};
    b_x    = {{DW{b_s}}, b};
    prod   = a_x * b_x;
    p_s    = (SIGNED != 0) ? prod[2*DW-1] : 1'b0;
    prod_x = {{(AW-2*DW){p_s}}, prod};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_x;
    end
  end

endmodule

// File: rtl/matmul_array.sv
// N x N output-stationary matmul: one rank-1 update per input beat,
// then C = W*X is streamed out one row per out_valid/out_ready handshake.
// Ports: start/k_len job launch; in_valid/in_ready with w_vec, x_vec beats;
// out_valid/out_ready with out_row, out_data rows; busy, done status.
module matmul_array
  import matmul_pkg::*;
#(
  parameter  int N      = 3,
  parameter  int DW     = 4,
  parameter  int K_MAX  = 16,
  parameter  int SIGNED = 0,
  localparam int AW     = acc_width(DW, K_MAX),
  localparam int KW     = $clog2(K_MAX + 1),
  localparam int RW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] w_vec,
  input  logic [N*DW-1:0] x_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RW-1:0]   out_row,
  output logic [N*AW-1:0] out_data,
  output logic            busy,
  output logic            done
);

  state_t        state_q;
  state_t        state_d;
  logic [KW-1:0] klen_q;
  logic [KW-1:0] beat_q;
  logic [RW-1:0] row_q;
  logic          done_q;

  logic          start_ok;
  logic          clr;
  logic          beat;
  logic          last_beat;
  logic          row_fire;
  logic          last_row;

  logic [AW-1:0] acc [N][N];

  assign start_ok  = start && (k_len != '0) &&
                     (k_len <= KW'(K_MAX));
  assign clr       = (state_q == IDLE) && start_ok;
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (beat_q == klen_q - 1'b1);
  assign row_fire  = out_valid && out_ready;
  assign last_row  = row_fire && (row_q == RW'(N - 1));

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign out_row   = row_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok)  state_d = ACC;
      ACC:     if (last_beat) state_d = DRAIN;
      DRAIN:   if (last_row)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_row;
      if (clr) begin
        klen_q <= k_len;
        beat_q <= '0;
      end else if (beat) begin
        beat_q <= beat_q + 1'b1;
      end
      if (last_row) begin
        row_q <= '0;
      end else if (row_fire) begin
        row_q <= row_q + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      mac_cell #(
        .DW    (DW),
        .AW    (AW),
        .SIGNED(SIGNED)
      ) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .en   (beat),
        .a    (`MM_LANE(w_vec, i, DW)),
        .b    (`MM_LANE(x_vec, j, DW)),
        .acc  (acc[i][j])
      );
    end
  end

  // Rows are only exposed while draining so idle outputs stay at zero.
  always_comb begin
    out_data = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < N; j++) begin
        `MM_LANE(out_data, j, AW) = acc[row_q][j];
      end
    end
  end

endmodule

// File: tb/tb_matmul_array.sv
// Random and directed jobs on unsigned and signed arrays in lockstep.
// Expected rows come from plain matrix sums, checked by a queue monitor.
module tb_matmul_array;

  localparam int N     = 3;
  localparam int DW    = 4;
  localparam int K_MAX = 16;
  localparam int AW    = 2 * DW + $clog2(K_MAX + 1);
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int RW    = 2;

  typedef struct packed {
    logic [RW-1:0]   row;
    logic [N*AW-1:0] data;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic [N*DW-1:0] w_vec;
  logic [N*DW-1:0] x_vec;
  logic            out_ready;

  logic            in_rdy [2];
  logic            ov     [2];
  logic [RW-1:0]   orow   [2];
  logic [N*AW-1:0] od     [2];
  logic            bsy    [2];
  logic            dn     [2];

  int checks;
  int failures;
  int jobs_done;
  int or_mode;

  int wm [N][K_MAX];
  int xm [K_MAX][N];

  exp_t q0 [$];
  exp_t q1 [$];

  matmul_array #(
    .N(N), .DW(DW), .K_MAX(K_MAX), .SIGNED(0)
  ) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_rdy[0]),
    .w_vec(w_vec), .x_vec(x_vec),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_row(orow[0]), .out_data(od[0]),
    .busy(bsy[0]), .done(dn[0])
  );

  matmul_array #(
    .N(N), .DW(DW), .K_MAX(K_MAX), .SIGNED(1)
  ) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_rdy[1]),
    .w_vec(w_vec), .x_vec(x_vec),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_row(orow[1]), .out_data(od[1]),
    .busy(bsy[1]), .done(dn[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic longint sx(input int v, input int s);
    if (s != 0 && v >= (1 << (DW - 1))) return longint'(v - (1 << DW));
    return longint'(v);
  endfunction

  task automatic push_expected(input int kl);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        exp_t e;
        e.row  = RW'(i);
        e.data = '0;
        for (int j = 0; j < N; j++) begin
          longint c;
          c = 0;
          for (int k = 0; k < kl; k++)
            c += sx(wm[i][k], d) * sx(xm[k][j], d);
          e.data[j*AW +: AW] = c[AW-1:0];
        end
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endtask

  // Output monitor: pops one expected row per handshake on each array.
  bit              exp_done [2];
  bit              hold     [2];
  logic [N*AW-1:0] hold_d   [2];
  logic [RW-1:0]   hold_r   [2];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        exp_done[d] = 1'b0;
        hold[d]     = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (hold[d]) begin
          chk($sformatf("hold_valid_d%0d", d), 64'(ov[d]), 64'(1));
          chk($sformatf("hold_data_d%0d", d), 64'(od[d]), 64'(hold_d[d]));
          chk($sformatf("hold_row_d%0d", d), 64'(orow[d]), 64'(hold_r[d]));
        end
        chk($sformatf("done_d%0d", d), 64'(dn[d]), 64'(exp_done[d]));
        exp_done[d] = 1'b0;
        if (ov[d] && out_ready) begin
          int sz;
          sz = (d == 0) ? q0.size() : q1.size();
          checks++;
          if (sz == 0) begin
            failures++;
            $display("FAIL unexpected_row_d%0d actual=%0h required=none",
                     d, od[d]);
          end else begin
            exp_t e;
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("row_d%0d", d), 64'(orow[d]), 64'(e.row));
            chk($sformatf("data_d%0d_r%0d", d, e.row),
                64'(od[d]), 64'(e.data));
            if (e.row == RW'(N - 1)) begin
              exp_done[d] = 1'b1;
              if (d == 0) jobs_done++;
            end
          end
        end
        hold[d]   = ov[d] && !out_ready;
        hold_d[d] = od[d];
        hold_r[d] = orow[d];
      end
    end
  end

  // Downstream: 0 always ready, 1 random, 2 low two of every three cycles.
  initial begin
    int c;
    c = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(1));
        default: out_ready = (c % 3 == 2);
      endcase
    end
  end

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_in_ready_d%0d", tag, d), 64'(in_rdy[d]), 0);
      chk($sformatf("%s_out_valid_d%0d", tag, d), 64'(ov[d]), 0);
      chk($sformatf("%s_out_row_d%0d", tag, d), 64'(orow[d]), 0);
      chk($sformatf("%s_out_data_d%0d", tag, d), 64'(od[d]), 0);
      chk($sformatf("%s_busy_d%0d", tag, d), 64'(bsy[d]), 0);
      chk($sformatf("%s_done_d%0d", tag, d), 64'(dn[d]), 0);
    end
  endtask

  task automatic drive_beat(input int k);
    for (int i = 0; i < N; i++) begin
      w_vec[i*DW +: DW] = DW'(wm[i][k]);
      x_vec[i*DW +: DW] = DW'(xm[k][i]);
    end
  endtask

  task automatic run_job(input int kl, input int stall_pct,
                         input int abort_at, input bit noisy);
    int k;
    int budget;
    int target;
    start = 1'b1;
    k_len = KW'(kl);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_acc", 64'(bsy[0]), 1);
    k = 0;
    budget = 0;
    while (k < kl) begin
      if ($urandom_range(99) < stall_pct) begin
        in_valid = 1'b0;
        w_vec = N*DW'($urandom);
        x_vec = N*DW'($urandom);
      end else begin
        in_valid = 1'b1;
        drive_beat(k);
      end
      start = noisy ? 1'($urandom_range(1)) : 1'b0;
      k_len = KW'($urandom_range(1, K_MAX));
      @(negedge clk);
      if (in_valid && in_rdy[0]) k++;
      budget++;
      @(posedge clk);
      #1;
      if (abort_at > 0 && k == abort_at) begin
        start = 1'b0;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (budget > 8 * kl + 40) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout actual=%0d required=%0d", k, kl);
        start = 1'b0;
        in_valid = 1'b0;
        return;
      end
    end
    start = 1'b0;
    push_expected(kl);
    chk("latency_out_valid", 64'(ov[0]), 1);
    chk("latency_in_ready", 64'(in_rdy[0]), 0);
    target = jobs_done + 1;
    budget = 0;
    while (jobs_done < target && budget < 200) begin
      in_valid = noisy ? 1'($urandom_range(1)) : 1'b0;
      w_vec = N*DW'($urandom);
      x_vec = N*DW'($urandom);
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (jobs_done < target) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=%0d",
               jobs_done, target);
    end
    @(posedge clk);
    #1;
    chk("busy_after_done", 64'(bsy[0]), 0);
  endtask

  task automatic fill_const(input int wv, input int xv);
    for (int k = 0; k < K_MAX; k++)
      for (int i = 0; i < N; i++) begin
        wm[i][k] = wv;
        xm[k][i] = xv;
      end
  endtask

  task automatic fill_t1();
    int v [3];
    v = '{3, 2, 3};
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) begin
        wm[i][k] = v[k];
        xm[k][i] = v[k];
      end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < K_MAX; k++)
      for (int i = 0; i < N; i++) begin
        wm[i][k] = int'($urandom_range((1 << DW) - 1));
        xm[k][i] = int'($urandom_range((1 << DW) - 1));
      end
  endtask

  task automatic try_bad_start(input int kl);
    start = 1'b1;
    k_len = KW'(kl);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bad_start_busy_k%0d", kl), 64'(bsy[0]), 0);
      chk($sformatf("bad_start_in_ready_k%0d", kl), 64'(in_rdy[1]), 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    jobs_done = 0;
    or_mode   = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    k_len     = '0;
    in_valid  = 1'b0;
    w_vec     = '0;
    x_vec     = '0;
    #1;
    check_idle("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fill_t1();
    run_job(3, 0, 0, 1'b0);

    fill_const(0, 0);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) begin
        wm[i][k] = (i == k) ? 1 : 0;
        xm[k][i] = 3 * k + i + 1;
      end
    run_job(3, 0, 0, 1'b0);

    fill_t1();
    or_mode = 2;
    run_job(3, 50, 0, 1'b0);
    or_mode = 0;

    fill_const(8, 7);
    run_job(16, 0, 0, 1'b0);

    fill_const(15, 15);
    run_job(16, 0, 0, 1'b0);

    fill_rand();
    run_job(5, 0, 2, 1'b0);
    fill_const(1, 1);
    run_job(1, 0, 0, 1'b0);
    try_bad_start(0);
    try_bad_start(20);

    for (int r = 0; r < 8; r++) begin
      fill_rand();
      or_mode = int'($urandom_range(2));
      run_job(int'($urandom_range(1, K_MAX)),
              int'($urandom_range(60)), 0, 1'b1);
    end
    or_mode = 0;

    repeat (5) @(posedge clk);
    #1;
    chk("q_unsigned_empty", 64'(q0.size()), 0);
    chk("q_signed_empty", 64'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
